inst_fetch_unit: RTL and testbench

Requester side of the single-cycle instruction memory. Owns the PC and issues read-only accesses (enable=1, wr=0) to the memory's combinational read port. Captures each returned 16-bit word with its PC into a small FIFO and presents the entries to decode over a valid/ready handshake. Handles redirects (branch/jump), halt, and reset boot sequencing.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/inst_fetch_unit.sv | 94 +++++++++
 tb/tb_inst_fetch_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// instruction word width and PC increment.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam int INST_WIDTH = 16;
  localparam int PC_STEP    = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, inst} entries with flush; the head output
// holds the last presented entry while the FIFO is empty.
module fetch_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] head;

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign rdata = empty ? hold_q : head;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = empty ? hold_q : head;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the single-cycle instruction
// memory and queues {pc, inst} entries for decode behind a valid/ready port.
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_enable,
  output logic                  mem_wr,
  output logic [INST_WIDTH-1:0] mem_data_in,
  input  logic [INST_WIDTH-1:0] mem_data_out,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  halted
);

  localparam int                    ENTRY_W = ADDR_WIDTH + INST_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] BOOT_PC = RESET_PC & ~ADDR_WIDTH'(1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  pop, fetch, flush;
  logic                  fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]    head;

  assign inst_valid = !fifo_empty;
  assign pop        = inst_valid && inst_ready;
  // Redirects are ignored while the memory image is still loading.
  assign flush      = redirect_valid && (state_q != BOOT);
  assign fetch      = (state_q == FETCH) && !halt && !redirect_valid &&
                      (!fifo_full || pop);

  assign mem_addr    = pc_q;
  assign mem_enable  = fetch;
  assign mem_wr      = 1'b0;
  assign mem_data_in = '0;
  assign halted      = (state_q == HALTED);
  assign {inst_pc, inst_data} = head;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH: begin
        if (halt)  state_d = HALTED;
        if (fetch) pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
      end
      HALTED:  state_d = HALTED;
      default: state_d = BOOT;
    endcase
    // Redirect overrides halt; halt is looked at again next cycle.
    if (flush) begin
      state_d = FETCH;
      pc_d    = redirect_pc & ~ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= BOOT_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (fetch),
    .pop   (pop),
    .flush (flush),
    .wdata ({pc_q, mem_data_out}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a behavioural instruction memory
// and a queue of expected delivered PCs checked on every accepted handshake.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;
  logic        halted;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h1111;
      16'h0002: mem_word = 16'h2222;
      16'h0004: mem_word = 16'h3333;
      default:  mem_word = a ^ 16'h5A5A;
    endcase
  endfunction

  assign mem_data_out = mem_word(mem_addr);

  inst_fetch_unit #(
    .ADDR_WIDTH (16),
    .RESET_PC   (16'h0000),
    .BUF_DEPTH  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .halted         (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Inputs change just after posedge, so a handshake seen here is the one
  // the next rising edge will accept.
  always @(negedge clk) begin
    chk("mem_wr", mem_wr, 0);
    chk("mem_data_in", mem_data_in, 0);
    if (rst === 1'b1 && inst_valid === 1'b1 && inst_ready === 1'b1) begin
      chk("pop_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("deliver_pc", inst_pc, e);
        chk("deliver_data", inst_data, mem_word(e));
      end
    end
  end

  initial begin
    rst = 1'b0; inst_ready = 1'b1; halt = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 16'h0000;
    step(3);
    chk("rst_valid", inst_valid, 0);
    chk("rst_mem_en", mem_enable, 0);
    chk("rst_halted", halted, 0);
    chk("rst_inst_pc", inst_pc, 0);
    chk("rst_inst_data", inst_data, 0);

    // Boot and stream
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0002);
    exp_q.push_back(16'h0004); exp_q.push_back(16'h0006);
    rst = 1'b1; #1;
    chk("boot_no_fetch", mem_enable, 0);
    step(1);
    chk("first_fetch_en", mem_enable, 1);
    chk("first_fetch_addr", mem_addr, 16'h0000);
    chk("first_fetch_no_valid", inst_valid, 0);
    step(1);
    chk("t1_valid0", inst_valid, 1);
    chk("t1_pc0", inst_pc, 16'h0000);
    chk("t1_data0", inst_data, 16'h1111);
    step(1);
    chk("t1_pc1", inst_pc, 16'h0002);
    chk("t1_data1", inst_data, 16'h2222);
    step(1);
    chk("t1_pc2", inst_pc, 16'h0004);
    chk("t1_data2", inst_data, 16'h3333);
    step(1);
    chk("t1_pc3", inst_pc, 16'h0006);
    inst_ready = 1'b0;
    step(1);
    chk("t6_full_valid", inst_valid, 1);
    chk("t6_full_no_fetch", mem_enable, 0);

    // Asynchronous reset with two entries buffered
    rst = 1'b0; #1;
    chk("t6_async_valid", inst_valid, 0);
    chk("t6_async_mem_en", mem_enable, 0);
    chk("t6_async_inst_pc", inst_pc, 0);
    chk("t6_async_inst_data", inst_data, 0);
    chk("t6_outstanding", exp_q.size(), 1);
    exp_q.delete();
    step(1);
    chk("t6_held_valid", inst_valid, 0);

    // Backpressure from a fresh boot
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0002); exp_q.push_back(16'h0004);
    rst = 1'b1;
    step(1);
    chk("t2_fetch0_en", mem_enable, 1);
    chk("t2_fetch0_addr", mem_addr, 16'h0000);
    step(1);
    chk("t2_fetch1_en", mem_enable, 1);
    chk("t2_fetch1_addr", mem_addr, 16'h0002);
    step(1);
    chk("t2_full_mem_en", mem_enable, 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t2_hold_mem_en", mem_enable, 0);
      chk("t2_hold_pc", inst_pc, 16'h0000);
      chk("t2_hold_data", inst_data, 16'h1111);
    end
    inst_ready = 1'b1; #1;
    chk("t2_refetch_en", mem_enable, 1);
    chk("t2_refetch_addr", mem_addr, 16'h0004);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("t2_no_gap", inst_valid, 1);
    end
    chk("t2_head_after_drain", inst_pc, 16'h0006);
    inst_ready = 1'b0;
    chk("t2_sb_empty", exp_q.size(), 0);

    // Redirect while full
    redirect_valid = 1'b1; redirect_pc = 16'h0041; #1;
    chk("t3_no_fetch_on_redirect", mem_enable, 0);
    step(1);
    redirect_valid = 1'b0; inst_ready = 1'b1;
    exp_q.push_back(16'h0040); exp_q.push_back(16'h0042);
    #1;
    chk("t3_flushed", inst_valid, 0);
    chk("t3_resume_en", mem_enable, 1);
    chk("t3_resume_addr", mem_addr, 16'h0040);
    step(1);
    chk("t3_head_valid", inst_valid, 1);
    chk("t3_head_pc", inst_pc, 16'h0040);
    inst_ready = 1'b0;
    step(1);
    chk("t3_full", mem_enable, 0);

    // Halt drains buffered entries, resumes only on redirect
    halt = 1'b1; inst_ready = 1'b1; #1;
    chk("t4_halt_no_fetch", mem_enable, 0);
    step(1);
    chk("t4_halted", halted, 1);
    chk("t4_mem_en", mem_enable, 0);
    chk("t4_drain_valid", inst_valid, 1);
    chk("t4_drain_pc", inst_pc, 16'h0042);
    step(1);
    chk("t4_drained", inst_valid, 0);
    halt = 1'b0; #1;
    chk("t4_unhalt_no_fetch", mem_enable, 0);
    step(2);
    chk("t4_still_halted", halted, 1);
    chk("t4_still_no_fetch", mem_enable, 0);
    chk("t4_sb_empty", exp_q.size(), 0);
    exp_q.push_back(16'h0100); exp_q.push_back(16'h0102);
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    step(1);
    redirect_valid = 1'b0; #1;
    chk("t4_resumed", halted, 0);
    chk("t4_resume_en", mem_enable, 1);
    chk("t4_resume_addr", mem_addr, 16'h0100);
    step(1);
    chk("t4_head_pc0", inst_pc, 16'h0100);
    step(1);
    chk("t4_head_pc1", inst_pc, 16'h0102);

    // Wrap past the top of the address space; 0x0102 pops with the redirect
    exp_q.push_back(16'hFFFC); exp_q.push_back(16'hFFFE); exp_q.push_back(16'h0000);
    redirect_valid = 1'b1; redirect_pc = 16'hFFFC;
    step(1);
    redirect_valid = 1'b0; #1;
    chk("t5_flushed", inst_valid, 0);
    chk("t5_addr", mem_addr, 16'hFFFC);
    step(2);
    chk("t5_wrap_addr", mem_addr, 16'h0000);
    step(1);
    halt = 1'b1; #1;
    chk("t5_halt_no_fetch", mem_enable, 0);
    step(1);
    chk("t5_halted", halted, 1);
    chk("t5_empty", inst_valid, 0);
    chk("t5_sb_empty", exp_q.size(), 0);

    // Redirect and halt together: redirect wins for one cycle
    redirect_valid = 1'b1; redirect_pc = 16'h0200;
    step(1);
    redirect_valid = 1'b0; #1;
    chk("both_fetch_state", halted, 0);
    chk("both_no_fetch", mem_enable, 0);
    step(1);
    chk("both_rehalted", halted, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
